// File: rtl/Bundle.sv
// Shared payload types and constants for the register-file writeback path.
package Bundle;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } WbEntry;

  localparam logic [REG_AW-1:0] RF_ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_wb_fifo.sv
// Writeback queue storage and pointers; exposes the head entry and, when
// RF_WRITEBACK_BYPASS_EN is defined, an age-ordered view (index 0 = oldest).
module rf_wb_fifo
  import Bundle::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  WbEntry              wr_entry,
  output WbEntry              head,
`ifdef RF_WRITEBACK_BYPASS_EN
  output WbEntry [DEPTH-1:0]  age_entry,
  output logic [DEPTH-1:0]    age_vld,
`endif
  output logic [CW-1:0]       count,
  output logic                empty
);

  WbEntry          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;

  // Pointer/occupancy state; flush discards everything at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign empty = (count_q == '0);

`ifdef RF_WRITEBACK_BYPASS_EN
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_entry[i] = mem[rd_ptr + AW'(i)];
      age_vld[i]   = (CW'(i) < count_q);
    end
  end
`endif

endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: queues producer results, gives the
// CSR/debug writer priority, drops x0 writes. Optional RF_WRITEBACK_BYPASS_EN.
module rf_writeback
  import Bundle::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_rd,
  input  logic [31:0]   in_data,
  input  logic          ext_we,
  input  logic [4:0]    ext_waddr,
  input  logic [31:0]   ext_wdata,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  input  logic [4:0]    fwd_rs1_addr,
  input  logic [4:0]    fwd_rs2_addr,
  output logic          fwd_rs1_hit,
  output logic          fwd_rs2_hit,
  output logic [31:0]   fwd_rs1_data,
  output logic [31:0]   fwd_rs2_data
);

  WbEntry head;
  WbEntry wr_entry;
  logic   push;
  logic   pop;
  logic   q_drive;

`ifdef RF_WRITEBACK_BYPASS_EN
  WbEntry [DEPTH-1:0] age_entry;
  logic [DEPTH-1:0]   age_vld;
`endif

  assign in_ready = rst_n && (count < CW'(DEPTH)) && !flush;
  // x0 results complete the handshake but never enter the queue.
  assign push     = in_valid && in_ready && (in_rd != RF_ZERO_REG);
  assign q_drive  = rst_n && !ext_we && !empty;
  assign pop      = q_drive && !flush;
  assign wr_entry = '{rd: in_rd, data: in_data};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_entry  (wr_entry),
    .head      (head),
`ifdef RF_WRITEBACK_BYPASS_EN
    .age_entry (age_entry),
    .age_vld   (age_vld),
`endif
    .count     (count),
    .empty     (empty)
  );

  // Write-port arbitration: external writer wins, queue head otherwise.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (rst_n && ext_we) begin
      rf_we    = 1'b1;
      rf_waddr = ext_waddr;
      rf_wdata = ext_wdata;
    end else if (q_drive) begin
      rf_we    = 1'b1;
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

`ifdef RF_WRITEBACK_BYPASS_EN
  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs2_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst_n && age_vld[i] && (fwd_rs1_addr != RF_ZERO_REG) &&
          (age_entry[i].rd == fwd_rs1_addr)) begin
        fwd_rs1_hit  = 1'b1;
        fwd_rs1_data = age_entry[i].data;
      end
      if (rst_n && age_vld[i] && (fwd_rs2_addr != RF_ZERO_REG) &&
          (age_entry[i].rd == fwd_rs2_addr)) begin
        fwd_rs2_hit  = 1'b1;
        fwd_rs2_data = age_entry[i].data;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: doc/rf_writeback.md
RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued writebacks (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, in_rd input 5, in_data input 32: result producer valid/ready channel.
REQ-005 SHALL have ports ext_we input 1, ext_waddr input 5, ext_wdata input 32: priority writer (CSR/debug) sharing the regfile write port.
REQ-006 SHALL have ports rf_we output 1, rf_waddr output 5, rf_wdata output 32: the RegisterFile write port (we/waddr/wdata of Bundle::RegisterFileIn).
REQ-007 SHALL have ports flush input 1, count output $clog2(DEPTH)+1 (queue occupancy), empty output 1.
REQ-008 SHALL have ports fwd_rs1_addr, fwd_rs2_addr input 5; fwd_rs1_hit, fwd_rs2_hit output 1; fwd_rs1_data, fwd_rs2_data output 32.

Function
REQ-009 SHALL transfer a producer result on each rising edge where in_valid && in_ready.
REQ-010 SHALL drive in_ready = (count < DEPTH) && !flush; no same-cycle pass-through when full.
REQ-011 SHALL discard accepted results with in_rd == 0 (handshake completes, nothing enqueued).
REQ-012 SHALL drive the write port combinationally: ext_we high -> rf_we=1, rf_waddr/rf_wdata = ext_*; else if queue non-empty -> rf_we=1, head entry; else rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-013 SHALL pop the head at the edge ending a cycle in which it drove rf_we (ext_we low, queue non-empty).
REQ-014 SHALL give latency one cycle minimum: entry accepted at edge N drives rf_we in cycle N+1 when ext_we low and queue otherwise empty.
REQ-015 SHALL write entries strictly in acceptance order; ext_we stalls the queue for as many cycles as asserted.
REQ-016 SHALL allow simultaneous push and pop when 0 < count < DEPTH; count unchanged.
REQ-017 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-018 SHALL on flush high empty the queue at that edge, ignore in_valid that cycle, still drive the current head if ext_we low (pop suppressed; entry dropped by flush).
REQ-019 SHALL assert empty exactly when count == 0.

Reset
REQ-020 SHALL on rst_n low at an edge set count=0, pointers=0; rf_we=0, in_ready=0 while rst_n low; fwd_*_hit=0.
REQ-021 SHALL drop queued entries on reset mid-operation; no rf_we in the cycle following the reset edge unless ext_we.

Configuration
REQ-022 SHALL gate forwarding with macro RF_WRITEBACK_BYPASS_EN.
REQ-023 SHALL with RF_WRITEBACK_BYPASS_EN defined: fwd_rsN_hit=1 when a queued entry matches fwd_rsN_addr (addr != 0); fwd_rsN_data = youngest matching entry; combinational.
REQ-024 SHALL with RF_WRITEBACK_BYPASS_EN undefined: ports present, fwd_*_hit and fwd_*_data tied 0, no comparators.

Structure
REQ-025 SHALL define typedef WbEntry (rd 5, data 32) and constant RF_ZERO_REG = 5'd0 in package Bundle.
REQ-026 SHALL place queue storage/pointers in one sub-module rf_wb_fifo; arbitration, x0 filter and forwarding in rf_writeback.

Verification
REQ-027 SHALL cover: push rd=5 data=0xDEADBEEF, ext_we=0 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; then empty=1.
REQ-028 SHALL cover: push rd=0 data=0x1234 -> in_ready=1, count stays 0, rf_we never asserted.
REQ-029 SHALL cover: ext_we=1 held 6 cycles, push rd=1..4 -> in_ready=0 after 4 pushes (DEPTH=4); release -> rf_waddr 1,2,3,4 on consecutive cycles.
REQ-030 SHALL cover (bypass on): queue rd=7 0x11 then rd=7 0x22, stall with ext_we, fwd_rs1_addr=7 -> hit=1, data=0x22; fwd_rs2_addr=0 -> hit=0.
REQ-031 SHALL cover: 3 entries queued, flush one cycle -> count=0, empty=1, no further rf_we; rst_n low with 2 queued -> rf_we=0 next cycle, count=0.
REQ-032 SHALL cover: 20 back-to-back pushes with ext_we toggling every 3 cycles -> all 20 written in order, pointer wrap exercised, no overflow.
